// File: rtl/reg_access_master.sv
// Host-side initiator for the UDP register-access protocol: serialises read/write
// requests into ASCII command frames and collects 4-byte big-endian read replies.
module reg_access_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [1:0]  i_cmd_reg,
    input  logic [31:0] i_cmd_wdata,
    output logic [7:0]  o_tx_udp_payload_axis_tdata,
    output logic        o_tx_udp_payload_axis_tvalid,
    output logic        o_tx_udp_payload_axis_tlast,
    input  logic        i_tx_udp_payload_axis_tready,
    input  logic [7:0]  i_rx_udp_payload_axis_tdata,
    input  logic        i_rx_udp_payload_axis_tvalid,
    input  logic        i_rx_udp_payload_axis_tlast,
    output logic        o_rx_udp_payload_axis_tready,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic [1:0]  o_rsp_status,
    output logic        o_busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RSP, S_DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_write;
    logic [1:0]      r_reg;
    logic [31:0]     r_wdata;
    logic [2:0]      r_byte_cnt;
    logic [7:0]      r_tx_tdata;
    logic            r_tx_tvalid;
    logic            r_tx_tlast;
    logic [TW-1:0]   r_tout;
    logic [31:0]     r_shreg;
    logic [2:0]      r_rx_cnt;
    logic            r_rsp_valid;
    logic [31:0]     r_rsp_rdata;
    logic [1:0]      r_rsp_status;

    logic            w_rx_ready;
    logic            w_cmd_hs;
    logic            w_tx_hs;
    logic            w_rx_hs;
    logic [2:0]      w_last_idx;
    logic            w_timeout;
    logic [31:0]     w_shreg_nxt;
    logic [2:0]      w_rx_cnt_nxt;
    logic            w_rsp_fire;
    logic [1:0]      w_rsp_status;
    logic [31:0]     w_rsp_rdata;

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic wr,
                                              input logic [1:0] rg, input logic [31:0] wd);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h3A;
            3'd1:    b = 8'h30 + {6'd0, rg};
            3'd2:    b = wr ? 8'h57 : 8'h52;
            3'd3:    b = wd[31:24];
            3'd4:    b = wd[23:16];
            3'd5:    b = wd[15:8];
            default: b = wd[7:0];
        endcase
        return b;
    endfunction

    assign w_rx_ready   = (r_state != S_SEND);
    assign w_cmd_hs     = i_cmd_valid && (r_state == S_IDLE);
    assign w_tx_hs      = (r_state == S_SEND) && r_tx_tvalid && i_tx_udp_payload_axis_tready;
    assign w_rx_hs      = i_rx_udp_payload_axis_tvalid && w_rx_ready;
    assign w_last_idx   = r_write ? 3'd6 : 3'd2;
    assign w_timeout    = ((r_state == S_WAIT_RSP) || (r_state == S_DRAIN)) &&
                          (r_tout == TW'(TIMEOUT_CYCLES - 1));
    assign w_shreg_nxt  = {r_shreg[23:0], i_rx_udp_payload_axis_tdata};
    assign w_rx_cnt_nxt = r_rx_cnt + 3'd1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // A completing beat outranks a timeout landing on the same edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_rsp_fire   = 1'b0;
        w_rsp_status = 2'd0;
        w_rsp_rdata  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_tx_hs && (r_byte_cnt == w_last_idx)) begin
                    if (r_write) begin
                        w_state_nxt = S_IDLE;
                        w_rsp_fire  = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_RSP;
                    end
                end
            end
            S_WAIT_RSP: begin
                if (w_rx_hs && i_rx_udp_payload_axis_tlast) begin
                    w_state_nxt = S_IDLE;
                    w_rsp_fire  = 1'b1;
                    if (w_rx_cnt_nxt == 3'd4) w_rsp_rdata  = w_shreg_nxt;
                    else                      w_rsp_status = 2'd2;
                end else if (w_timeout) begin
                    w_state_nxt  = S_IDLE;
                    w_rsp_fire   = 1'b1;
                    w_rsp_status = 2'd1;
                end else if (w_rx_hs && (w_rx_cnt_nxt == 3'd4)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_rx_hs && i_rx_udp_payload_axis_tlast) begin
                    w_state_nxt  = S_IDLE;
                    w_rsp_fire   = 1'b1;
                    w_rsp_status = 2'd3;
                    w_rsp_rdata  = r_shreg;
                end else if (w_timeout) begin
                    w_state_nxt  = S_IDLE;
                    w_rsp_fire   = 1'b1;
                    w_rsp_status = 2'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_write      <= 1'b0;
            r_reg        <= 2'd0;
            r_wdata      <= 32'd0;
            r_byte_cnt   <= 3'd0;
            r_tx_tdata   <= 8'd0;
            r_tx_tvalid  <= 1'b0;
            r_tx_tlast   <= 1'b0;
            r_tout       <= '0;
            r_shreg      <= 32'd0;
            r_rx_cnt     <= 3'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 32'd0;
            r_rsp_status <= 2'd0;
        end else begin
            r_rsp_valid <= w_rsp_fire;
            if (w_rsp_fire) begin
                r_rsp_status <= w_rsp_status;
                r_rsp_rdata  <= w_rsp_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        r_write     <= i_cmd_write;
                        r_reg       <= i_cmd_reg;
                        r_wdata     <= i_cmd_wdata;
                        r_byte_cnt  <= 3'd0;
                        r_tx_tdata  <= 8'h3A;
                        r_tx_tvalid <= 1'b1;
                        r_tx_tlast  <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (w_tx_hs) begin
                        if (r_byte_cnt == w_last_idx) begin
                            r_tx_tdata  <= 8'd0;
                            r_tx_tvalid <= 1'b0;
                            r_tx_tlast  <= 1'b0;
                            r_tout      <= '0;
                            r_shreg     <= 32'd0;
                            r_rx_cnt    <= 3'd0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                            r_tx_tdata <= frame_byte(r_byte_cnt + 3'd1, r_write, r_reg, r_wdata);
                            r_tx_tlast <= ((r_byte_cnt + 3'd1) == w_last_idx);
                        end
                    end
                end
                S_WAIT_RSP: begin
                    r_tout <= r_tout + TW'(1);
                    if (w_rx_hs) begin
                        r_shreg  <= w_shreg_nxt;
                        r_rx_cnt <= w_rx_cnt_nxt;
                    end
                end
                S_DRAIN: begin
                    r_tout <= r_tout + TW'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_cmd_ready                  = (r_state == S_IDLE);
    assign o_busy                       = (r_state != S_IDLE);
    assign o_rx_udp_payload_axis_tready = w_rx_ready;
    assign o_tx_udp_payload_axis_tdata  = r_tx_tdata;
    assign o_tx_udp_payload_axis_tvalid = r_tx_tvalid;
    assign o_tx_udp_payload_axis_tlast  = r_tx_tlast;
    assign o_rsp_valid                  = r_rsp_valid;
    assign o_rsp_rdata                  = r_rsp_rdata;
    assign o_rsp_status                 = r_rsp_status;

endmodule

// File: tb/tb_reg_access_master.sv
// Bench for reg_access_master: vector table of commands and replies, with a
// scoreboard that checks TX frames, responses and their cycle timing.
module tb_reg_access_master;
    localparam int TOUT = 16;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [1:0]  i_cmd_reg;
    logic [31:0] i_cmd_wdata;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tlast;
    logic        tx_tready;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid;
    logic        rx_tlast;
    logic        rx_tready;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_status;
    logic        o_busy;

    reg_access_master #(.TIMEOUT_CYCLES(TOUT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_write(i_cmd_write), .i_cmd_reg(i_cmd_reg), .i_cmd_wdata(i_cmd_wdata),
        .o_tx_udp_payload_axis_tdata(tx_tdata), .o_tx_udp_payload_axis_tvalid(tx_tvalid),
        .o_tx_udp_payload_axis_tlast(tx_tlast), .i_tx_udp_payload_axis_tready(tx_tready),
        .i_rx_udp_payload_axis_tdata(rx_tdata), .i_rx_udp_payload_axis_tvalid(rx_tvalid),
        .i_rx_udp_payload_axis_tlast(rx_tlast), .o_rx_udp_payload_axis_tready(rx_tready),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_status(o_rsp_status), .o_busy(o_busy)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        wr;
        logic [1:0]  rg;
        logic [31:0] wd;
        logic        tog;
        int          nrx;
        logic [63:0] rx;
        logic [1:0]  st;
        logic [31:0] rd;
    } vec_t;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] rd;
        logic        ref_rx;
        int          delta;
    } rsp_t;

    logic [8:0] tx_q[$];
    rsp_t       rsp_q[$];
    vec_t       vecs[8];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_tx_edge = 0;
    int last_rx_edge = 0;
    int tx_seen = 0;
    int rx_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_byte(input int k, input logic wr, input logic [1:0] rg,
                                              input logic [31:0] wd);
        case (k)
            0: return 8'h3A;
            1: return 8'h30 + {6'd0, rg};
            2: return wr ? 8'h57 : 8'h52;
            3: return wd[31:24];
            4: return wd[23:16];
            5: return wd[15:8];
            default: return wd[7:0];
        endcase
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // Monitor: samples at the falling edge, between bench drive and the next active edge.
    initial begin
        logic       prev_tv, prev_tr, prev_tl, prev_rv;
        logic [7:0] prev_td;
        logic [8:0] etx;
        rsp_t       er;
        int         refe;
        prev_tv = 1'b0; prev_tr = 1'b0; prev_tl = 1'b0; prev_rv = 1'b0; prev_td = 8'd0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                if (prev_tv && !prev_tr)
                    chk("tx_stall_hold", {22'd0, tx_tvalid, tx_tlast, tx_tdata},
                        {22'd0, 1'b1, prev_tl, prev_td});
                if (tx_tvalid && tx_tready) begin
                    tx_seen++;
                    last_tx_edge = cyc + 1;
                    if (tx_q.size() == 0) begin
                        chk("tx_unexpected_beat", {23'd0, tx_tlast, tx_tdata}, 32'hFFFF_FFFF);
                    end else begin
                        etx = tx_q.pop_front();
                        chk("tx_byte", {23'd0, tx_tlast, tx_tdata}, {23'd0, etx});
                    end
                end
                if (rx_tvalid && rx_tready) begin
                    rx_seen++;
                    last_rx_edge = cyc + 1;
                end
                if (o_rsp_valid) begin
                    chk("rsp_one_cycle", {31'd0, prev_rv}, 32'd0);
                    chk("rsp_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", {30'd0, o_rsp_status}, 32'hFFFF_FFFF);
                    end else begin
                        er = rsp_q.pop_front();
                        chk("rsp_status", {30'd0, o_rsp_status}, {30'd0, er.st});
                        chk("rsp_rdata", o_rsp_rdata, er.rd);
                        refe = er.ref_rx ? last_rx_edge : last_tx_edge;
                        chk("rsp_latency", 32'(cyc - refe), 32'(er.delta));
                    end
                end
                prev_tv = tx_tvalid; prev_tr = tx_tready; prev_tl = tx_tlast;
                prev_td = tx_tdata;  prev_rv = o_rsp_valid;
            end else begin
                prev_tv = 1'b0; prev_rv = 1'b0;
            end
        end
    end

    task automatic do_cmd(input logic wr, input logic [1:0] rg, input logic [31:0] wd);
        int n;
        n = 0;
        i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_reg = rg; i_cmd_wdata = wd;
        while (!o_cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (!o_cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
        step();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_tx(input logic tog);
        int n;
        n = 0;
        while (tx_q.size() > 0 && n < 100) begin
            if (tog) tx_tready = ~tx_tready;
            step();
            n++;
        end
        if (tx_q.size() > 0) begin
            chk("tx_drain_timeout", tx_q.size(), 32'd0);
            tx_q.delete();
        end
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (rsp_q.size() > 0 && n < 60) begin
            step();
            n++;
        end
        if (rsp_q.size() > 0) begin
            chk("rsp_wait_timeout", rsp_q.size(), 32'd0);
            rsp_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   nb;
        rsp_t r;
        nb = v.wr ? 7 : 3;
        tx_seen = 0;
        rx_seen = 0;
        for (int k = 0; k < nb; k++)
            tx_q.push_back({(k == nb - 1), model_byte(k, v.wr, v.rg, v.wd)});
        r.st = v.st;
        r.rd = v.rd;
        r.ref_rx = !v.wr && (v.nrx > 0);
        r.delta = (!v.wr && v.nrx == 0) ? TOUT : 0;
        rsp_q.push_back(r);
        tx_tready = !v.tog;
        do_cmd(v.wr, v.rg, v.wd);
        wait_tx(v.tog);
        tx_tready = 1'b1;
        chk("tx_handshakes", tx_seen, nb);
        if (!v.wr) begin
            for (int k = 0; k < v.nrx; k++) begin
                rx_tvalid = 1'b1;
                rx_tdata  = v.rx[63 - 8*k -: 8];
                rx_tlast  = (k == v.nrx - 1);
                step();
            end
            rx_tvalid = 1'b0;
            rx_tlast  = 1'b0;
        end
        wait_rsp();
        if (!v.wr) chk("rx_beats_consumed", rx_seen, v.nrx);
        chk("rsp_hold", {o_rsp_status, o_rsp_rdata[29:0]}, {v.st, v.rd[29:0]});
    endtask

    initial begin
        vecs[0] = '{wr:1'b1, rg:2'd2, wd:32'hDEADBEEF, tog:1'b0, nrx:0, rx:64'd0, st:2'd0, rd:32'd0};
        vecs[1] = '{wr:1'b0, rg:2'd1, wd:32'd0, tog:1'b0, nrx:4,
                    rx:64'h1234_5678_0000_0000, st:2'd0, rd:32'h12345678};
        vecs[2] = '{wr:1'b1, rg:2'd0, wd:32'h01020304, tog:1'b1, nrx:0, rx:64'd0, st:2'd0, rd:32'd0};
        vecs[3] = '{wr:1'b0, rg:2'd3, wd:32'd0, tog:1'b0, nrx:0, rx:64'd0, st:2'd1, rd:32'd0};
        vecs[4] = '{wr:1'b0, rg:2'd0, wd:32'd0, tog:1'b0, nrx:2,
                    rx:64'h1122_0000_0000_0000, st:2'd2, rd:32'd0};
        vecs[5] = '{wr:1'b0, rg:2'd2, wd:32'd0, tog:1'b0, nrx:5,
                    rx:64'hAABB_CCDD_EE00_0000, st:2'd3, rd:32'hAABBCCDD};
        vecs[6] = '{wr:1'b0, rg:2'd1, wd:32'd0, tog:1'b1, nrx:1,
                    rx:64'h5A00_0000_0000_0000, st:2'd2, rd:32'd0};
        vecs[7] = '{wr:1'b1, rg:2'd3, wd:32'hFFFF_FFFF, tog:1'b0, nrx:0, rx:64'd0, st:2'd0, rd:32'd0};

        i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_reg = 2'd0;
        i_cmd_wdata = 32'd0; tx_tready = 1'b1; rx_tdata = 8'd0; rx_tvalid = 1'b0; rx_tlast = 1'b0;
        repeat (3) step();
        chk("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        chk("rst_rx_tready", {31'd0, rx_tready}, 32'd1);
        chk("rst_tx_tvalid", {31'd0, tx_tvalid}, 32'd0);
        chk("rst_tx_tlast",  {31'd0, tx_tlast}, 32'd0);
        chk("rst_tx_tdata",  {24'd0, tx_tdata}, 32'd0);
        chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("rst_rsp_status", {30'd0, o_rsp_status}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        i_rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of a write, right after the byte-3 handshake.
        for (int k = 0; k < 4; k++)
            tx_q.push_back({1'b0, model_byte(k, 1'b1, 2'd0, 32'h12345678)});
        do_cmd(1'b1, 2'd0, 32'h12345678);
        wait_tx(1'b0);
        tx_tready = 1'b0;
        i_rst_n = 1'b0;
        step();
        chk("midrst_tx_tvalid", {31'd0, tx_tvalid}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        i_rst_n = 1'b1;
        tx_tready = 1'b1;

        // Stray RX traffic while idle is swallowed silently.
        for (int k = 0; k < 3; k++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = 8'h60 + 8'(k);
            rx_tlast  = (k == 2);
            chk("idle_rx_tready", {31'd0, rx_tready}, 32'd1);
            step();
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 8; k++) begin
                seen = seen | o_rsp_valid | tx_tvalid;
                step();
            end
            chk("idle_no_activity", {31'd0, seen}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
